// File: rtl/hart_sequencer.sv
// Multi-cycle hart control FSM: fetch/decode/execute/mem/writeback sequencing,
// shared memory-port arbitration, trap detection and a bus watchdog.
module hart_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       rf_write,
  output logic [1:0] rf_src,
  output logic       instret,
  output logic       halted,
  output logic [1:0] trap_cause
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int            CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wd_cnt;
  logic [1:0]    cause_q, cause_nxt;
  logic          wd_wait, wd_expire, is_jump;

  assign wd_wait   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ack;
  assign wd_expire = (MEM_TIMEOUT != 0) && wd_wait && (wd_cnt == WD_LIMIT);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      wd_cnt  <= '0;
      cause_q <= 2'd0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      // Count only consecutive unacked cycles of the same request.
      if (wd_wait && (state_nxt == state)) wd_cnt <= wd_cnt + 1'b1;
      else                                 wd_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    rf_write     = 1'b0;
    rf_src       = 2'd0;
    instret      = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_nxt = S_WB;
          OPC_JAL, OPC_JALR: begin
            state_nxt = S_WB;
            rf_src    = 2'd2;
            pc_sel    = 1'b1;
          end
          OPC_LOAD, OPC_STORE: state_nxt = S_MEM;
          OPC_BRANCH: begin
            pc_write  = 1'b1;
            pc_sel    = branch_taken;
            instret   = 1'b1;
            state_nxt = S_FETCH;
          end
          OPC_SYSTEM: begin
            state_nxt = S_TRAP;
            cause_nxt = 2'd3;
          end
          default: begin
            state_nxt = S_TRAP;
            cause_nxt = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OPC_STORE);
        if (mem_ack) begin
          if (opcode == OPC_STORE) begin
            pc_write  = 1'b1;
            instret   = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            rf_src    = 2'd1;
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_write  = 1'b1;
        pc_write  = 1'b1;
        instret   = 1'b1;
        pc_sel    = is_jump;
        rf_src    = is_jump ? 2'd2 : ((opcode == OPC_LOAD) ? 2'd1 : 2'd0);
        state_nxt = S_FETCH;
      end
      S_TRAP: ;
      default: state_nxt = S_FETCH;
    endcase
    // Ack on the limit cycle never reaches here since wd_wait requires !mem_ack.
    if (wd_expire) begin
      state_nxt = S_TRAP;
      cause_nxt = 2'd2;
    end
  end

  assign halted     = (state == S_TRAP);
  assign trap_cause = cause_q;
endmodule

// File: tb/tb_hart_sequencer.sv
// Bench for hart_sequencer: a wait-state memory responder plus a per-instruction
// model of latency and strobe counts derived from the instruction class.
module tb_hart_sequencer;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
    JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011,
    OP_IMM = 7'b0010011, OP = 7'b0110011, SYSTEM = 7'b1110011;

  logic       clk = 1'b0, reset_n = 1'b0, branch_taken = 1'b0, mem_ack = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_sel, rf_write, instret, halted;
  logic [1:0] rf_src, trap_cause;

  always #5 clk = ~clk;

  hart_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .rf_write(rf_write),
    .rf_src(rf_src), .instret(instret), .halted(halted), .trap_cause(trap_cause)
  );

  int         nvec = 0, nerr = 0;
  int         want_f = 0, want_d = 0, fcnt = 0, dcnt = 0;
  logic [6:0] cur_op = 7'd0;
  bit         tk_g = 1'b0, rst_g = 1'b0, load_pend = 1'b0;
  logic       s_req, s_sel, s_we, s_ir, s_pcw, s_pcsel, s_rfw, s_ret, s_halt;
  logic [1:0] s_rfsrc, s_tc;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Instruction class: 0 alu, 1 jump, 2 load, 3 store, 4 branch, 5 system, 6 illegal
  function automatic int op_class(input logic [6:0] op);
    if (op == OP || op == OP_IMM || op == LUI || op == AUIPC) return 0;
    if (op == JAL || op == JALR) return 1;
    if (op == LOAD)   return 2;
    if (op == STORE)  return 3;
    if (op == BRANCH) return 4;
    if (op == SYSTEM) return 5;
    return 6;
  endfunction

  // One clock: drive at negedge, ack after request settles, sample mid-low phase.
  task automatic cycle();
    @(negedge clk);
    reset_n      = rst_g;
    branch_taken = tk_g;
    mem_ack      = 1'b0;
    if (load_pend) begin opcode = cur_op; load_pend = 1'b0; end
    #1;
    if (mem_req && reset_n) mem_ack = mem_addr_sel ? (dcnt == want_d) : (fcnt == want_f);
    #1;
    s_req = mem_req; s_sel = mem_addr_sel; s_we = mem_we; s_ir = ir_load;
    s_pcw = pc_write; s_pcsel = pc_sel; s_rfw = rf_write; s_rfsrc = rf_src;
    s_ret = instret; s_halt = halted; s_tc = trap_cause;
    if (mem_req && !mem_ack) begin
      if (mem_addr_sel) dcnt++; else fcnt++;
    end
    if (ir_load && reset_n) load_pend = 1'b1;
  endtask

  task automatic do_reset();
    want_f = 99; want_d = 99;
    rst_g = 1'b0;
    cycle();
    cycle();
    chk("rst_cause", s_tc, 0);
    chk("rst_halted", s_halt, 0);
    chk("rst_fetch_req", s_req && !s_sel && !s_we, 1);
    rst_g = 1'b1;
  endtask

  task automatic trap_hold();
    int nreq = 0, nrun = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_req) nreq++;
      if (!s_halt) nrun++;
    end
    chk("trap_no_req", nreq, 0);
    chk("trap_sticky", nrun, 0);
    do_reset();
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit tk);
    int c_ret = 0, c_halt = 0, n_f = 0, n_d = 0, n_we = 0, n_ir = 0, n_rf = 0;
    int rsrc = -1, n_pc = 0, psel = -1, n_ret = 0, first = 0;
    int cls = op_class(op);
    int lat;
    cur_op = op; want_f = fw; want_d = mw; fcnt = 0; dcnt = 0; tk_g = tk;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (i == 1) first = (s_req && !s_sel) ? 1 : 0;
      if (s_halt) begin c_halt = i; break; end
      if (s_req && !s_sel) n_f++;
      if (s_req && s_sel) n_d++;
      if (s_req && s_we) n_we++;
      if (s_ir) n_ir++;
      if (s_rfw) begin n_rf++; rsrc = s_rfsrc; end
      if (s_pcw) begin n_pc++; psel = s_pcsel; end
      if (s_ret) begin n_ret++; c_ret = i; break; end
    end
    chk("fetch_first_cycle", first, 1);
    chk("fetch_req_cycles", n_f, fw + 1);
    chk("ir_load_pulses", n_ir, 1);
    if (cls >= 5) begin
      chk("halt_cycle", c_halt, fw + 4);
      chk("trap_cause", s_tc, (cls == 5) ? 3 : 1);
      chk("trap_no_retire", n_ret + n_rf + n_pc, 0);
      trap_hold();
    end else begin
      lat = fw + 3 + ((cls == 2 || cls == 3) ? mw + 1 : 0) + ((cls <= 2) ? 1 : 0);
      chk("retire_cycle", c_ret, lat);
      chk("no_halt", c_halt, 0);
      chk("data_req_cycles", n_d, (cls == 2 || cls == 3) ? mw + 1 : 0);
      chk("store_we_cycles", n_we, (cls == 3) ? mw + 1 : 0);
      chk("rf_write_pulses", n_rf, (cls <= 2) ? 1 : 0);
      if (cls <= 2) chk("rf_src", rsrc, (cls == 2) ? 1 : (cls == 1) ? 2 : 0);
      chk("pc_write_pulses", n_pc, 1);
      chk("pc_sel", psel, (cls == 1) ? 1 : (cls == 4) ? int'(tk) : 0);
      chk("instret_pulses", n_ret, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] optab [12];
    int n, h, found, npc, nret, k;
    optab = '{OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, SYSTEM, 7'h7F, 7'h0F};

    do_reset();
    run_instr(OP_IMM, 0, 0, 1'b0);
    run_instr(LOAD, 0, 3, 1'b0);
    run_instr(BRANCH, 0, 0, 1'b1);
    run_instr(BRANCH, 0, 0, 1'b0);
    run_instr(7'h7F, 0, 0, 1'b0);
    run_instr(SYSTEM, 1, 0, 1'b0);

    // Watchdog: never ack the fetch
    do_reset();
    cur_op = OP_IMM; want_f = 99; fcnt = 0; n = 0; h = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (s_halt) begin h = i; break; end
      if (s_req) n++;
    end
    chk("wd_req_cycles", n, 4);
    chk("wd_halt_cycle", h, 5);
    chk("wd_cause", s_tc, 2);
    do_reset();
    run_instr(OP_IMM, 3, 0, 1'b0);
    run_instr(STORE, 0, 3, 1'b0);

    // Reset in the middle of a store's data request
    cur_op = STORE; want_f = 0; want_d = 99; fcnt = 0; dcnt = 0;
    found = 0; npc = 0; nret = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (s_pcw) npc++;
      if (s_ret) nret++;
      if (s_req && s_sel) begin found = 1; break; end
    end
    chk("st_mem_reached", found, 1);
    chk("st_mem_we", s_we, 1);
    rst_g = 1'b0;
    cycle();
    if (s_pcw) npc++;
    rst_g = 1'b1; want_f = 99;
    cycle();
    chk("st_abort_fetch", s_req && !s_sel, 1);
    chk("st_abort_we", s_we, 0);
    chk("st_abort_ret", s_ret, 0);
    chk("st_abort_pcw", npc + nret, 0);
    do_reset();

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 11);
      run_instr(optab[k], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
